// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES wait cycles, lane-merged stores, extended loads.
// Define DMEM_ERR_CHECK_EN to reject misaligned, size=11 and out-of-range requests with resp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        size_reg, size_next;
  logic              uns_reg, uns_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              commit;

  // With zero wait states the commit edge is also the accept edge, so the
  // array port must see the live request while IDLE and the latched one otherwise.
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size;
  logic [31:0]       cur_wdata;
  logic              illegal;

  assign cur_we    = (state_reg == S_IDLE) ? req_we    : we_reg;
  assign cur_addr  = (state_reg == S_IDLE) ? req_addr  : addr_reg;
  assign cur_size  = (state_reg == S_IDLE) ? req_size  : size_reg;
  assign cur_wdata = (state_reg == S_IDLE) ? req_wdata : wdata_reg;

  assign req_ready  = (state_reg == S_IDLE) && !rst;
  assign resp_valid = (state_reg == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    wdata_next = wdata_reg;
    commit     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          addr_next  = req_addr;
          size_next  = req_size;
          uns_next   = req_unsigned;
          wdata_next = req_wdata;
          if (WAIT_STATES == 0) begin
            state_next = S_RESP;
            commit     = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = S_RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  logic [ADDR_W-1:0] addr_hi;
  assign addr_hi = cur_addr >> (IDX_W + 2);
  assign illegal = (cur_size == 2'b11) ||
                   ((cur_size == 2'b01) && cur_addr[0]) ||
                   ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00)) ||
                   (addr_hi != '0);
`else
  // Upper address bits simply wrap the index; keep them visibly consumed.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cur_addr;
  assign illegal = 1'b0;
`endif

  assign resp_err = (state_reg == S_RESP) && illegal;

  logic [IDX_W-1:0] idx;
  logic [3:0]       lane_en;
  logic [31:0]      wdata_lanes;
  logic [31:0]      rd_word;

  assign idx = cur_addr[2 +: IDX_W];

  // Store data is replicated across lanes so each lane just picks its own byte.
  always_comb begin
    lane_en     = 4'b1111;
    wdata_lanes = cur_wdata;
    case (cur_size)
      2'b00: begin
        lane_en     = 4'b0001 << cur_addr[1:0];
        wdata_lanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_en     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        lane_en     = 4'b1111;
        wdata_lanes = cur_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte;
      always_ff @(posedge clk) begin
        if (commit && cur_we && !illegal && lane_en[gi])
          mem[idx] <= wdata_lanes[gi*8 +: 8];
        if (commit && !cur_we)
          rd_byte <= mem[idx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte;
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  always_comb begin
    sel_byte = rd_word[{addr_reg[1:0], 3'b000} +: 8];
    sel_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_reg)
      2'b00:   load_ext = uns_reg ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = uns_reg ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_ext = rd_word;
    endcase
  end

  assign resp_rdata = ((state_reg == S_RESP) && !we_reg && !illegal) ? load_ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_valid0 = 1'b0;
  logic resp_ready = 1'b0, resp_ready0 = 1'b0;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0] req_size = 2'b00;
  logic req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;

  logic req_ready, resp_valid, resp_err, req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata, resp_rdata0;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  logic sel = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0), .resp_err(resp_err0));

  wire        o_ready  = sel ? req_ready0  : req_ready;
  wire        o_rvalid = sel ? resp_valid0 : resp_valid;
  wire [31:0] o_rdata  = sel ? resp_rdata0 : resp_rdata;
  wire        o_err    = sel ? resp_err0   : resp_err;

  // Runs one request from a negedge with the selected DUT idle; returns at the negedge after the response handshake.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic ready_low, output logic stable, output int acc_cycle);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    ready_low = 1'b1; stable = 1'b1; rdata = 'x; err = 1'bx;
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL req_ready_idle addr=%h: got %b want 1", addr, o_ready);
    end
    @(negedge clk);
    acc_cycle = cycle;
    req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = ~we; req_addr = ~addr; req_size = ~size; req_unsigned = ~uns; req_wdata = ~wdata;
    lat = 1;
    while (o_rvalid !== 1'b1 && lat < 20) begin
      if (o_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (o_rvalid !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout addr=%h: got resp_valid=%b want 1 within 20 cycles", addr, o_rvalid);
    end else begin
      rdata = o_rdata; err = o_err;
      if (o_ready !== 1'b0) ready_low = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (o_rvalid !== 1'b1 || o_rdata !== rdata || o_err !== err || o_ready !== 1'b0) stable = 1'b0;
      end
      if (sel) resp_ready0 = 1'b1; else resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0; resp_ready0 = 1'b0;
    end
    $display("xact we=%b addr=%h size=%b uns=%b wdata=%h -> rdata=%h err=%b lat=%0d", we, addr, size, uns, wdata, rdata, err, lat);
  endtask

  logic [31:0] rd;
  logic er, rl, st;
  int lt, ac, ac_prev;

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    vectors++; if (resp_valid !== 1'b0 || resp_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b/%b want 0/0", resp_valid, resp_valid0); end
    vectors++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_data: got %h/%b want 0/0", resp_rdata, resp_err); end
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b/%b want 1/1", req_ready, req_ready0); end
    @(negedge clk);
  endtask

  task automatic test_word;
    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er, lt, rl, st, ac);
    vectors++; if (lt !== 3) begin miscompares++; $display("FAIL store_latency: got %0d want 3", lt); end
    vectors++; if (rl !== 1'b1) begin miscompares++; $display("FAIL busy_ready: got ready_low=%b want 1", rl); end
    vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL store_resp: got %h/%b want 00000000/0", rd, er); end
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_word: got %h want deadbeef", rd); end
    vectors++; if (lt !== 3) begin miscompares++; $display("FAIL load_latency: got %0d want 3", lt); end
  endtask

  task automatic test_byte;
    xact(1'b1, 32'h12, 2'b00, 1'b0, 32'hAAAAAA80, 0, rd, er, lt, rl, st, ac);
    xact(1'b0, 32'h12, 2'b00, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL load_byte_s: got %h want ffffff80", rd); end
    xact(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h00000080) begin miscompares++; $display("FAIL load_byte_u: got %h want 00000080", rd); end
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'hDE80BEEF) begin miscompares++; $display("FAIL byte_merge: got %h want de80beef", rd); end
    xact(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h000000DE) begin miscompares++; $display("FAIL load_byte3_u: got %h want 000000de", rd); end
  endtask

  task automatic test_half_backpressure;
    xact(1'b1, 32'h20, 2'b10, 1'b0, 32'h00000000, 0, rd, er, lt, rl, st, ac);
    xact(1'b1, 32'h20, 2'b01, 1'b0, 32'hFFFF1234, 4, rd, er, lt, rl, st, ac);
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL backpressure_stable: got %b want 1", st); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL half_store_resp: got %h want 00000000", rd); end
    xact(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h00000000) begin miscompares++; $display("FAIL load_half_hi: got %h want 00000000", rd); end
    xact(1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h00001234) begin miscompares++; $display("FAIL load_half_lo: got %h want 00001234", rd); end
    xact(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'hFFFFDE80) begin miscompares++; $display("FAIL load_half_s: got %h want ffffde80", rd); end
    xact(1'b0, 32'h10, 2'b10, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'hDE80BEEF) begin miscompares++; $display("FAIL word_ignores_uns: got %h want de80beef", rd); end
  endtask

  task automatic test_err;
    logic [31:0] exp_w8, exp_alias;
    logic exp_err;
`ifdef DMEM_ERR_CHECK_EN
    exp_err = 1'b1; exp_w8 = 32'h00001234; exp_alias = 32'h0;
`else
    exp_err = 1'b0; exp_w8 = 32'h99999999; exp_alias = 32'h55AA00FF;
`endif
    xact(1'b1, 32'h0, 2'b10, 1'b0, 32'h55AA00FF, 0, rd, er, lt, rl, st, ac);
    xact(1'b1, 32'h21, 2'b10, 1'b0, 32'h99999999, 0, rd, er, lt, rl, st, ac);
    vectors++; if (er !== exp_err || rd !== 32'h0) begin miscompares++; $display("FAIL misaligned_store: got err=%b rdata=%h want err=%b rdata=00000000", er, rd, exp_err); end
    vectors++; if (lt !== 3) begin miscompares++; $display("FAIL err_latency: got %0d want 3", lt); end
    xact(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== exp_w8 || er !== 1'b0) begin miscompares++; $display("FAIL word8_after_misaligned: got %h/%b want %h/0", rd, er, exp_w8); end
    xact(1'b0, 32'(4 * DEPTH), 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== exp_alias || er !== exp_err) begin miscompares++; $display("FAIL out_of_range_load: got %h/%b want %h/%b", rd, er, exp_alias, exp_err); end
  endtask

  task automatic test_reset_mid;
    xact(1'b1, 32'h30, 2'b10, 1'b0, 32'h11223344, 0, rd, er, lt, rl, st, ac);
    req_we = 1'b1; req_addr = 32'h30; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL in_wait: got ready=%b valid=%b want 0/0", req_ready, resp_valid); end
    rst = 1'b1;
    #1;
    vectors++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin miscompares++; $display("FAIL mid_reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 0/0/0/0", req_ready, resp_valid, resp_rdata, resp_err); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_release: got %b want 1", req_ready); end
    @(negedge clk);
    xact(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h11223344) begin miscompares++; $display("FAIL store_discarded: got %h want 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    sel = 1'b1;
    xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h0BADF00D, 0, rd, er, lt, rl, st, ac);
    vectors++; if (lt !== 1) begin miscompares++; $display("FAIL w0_store_latency: got %0d want 1", lt); end
    xact(1'b1, 32'h44, 2'b10, 1'b0, 32'h13579BDF, 0, rd, er, lt, rl, st, ac_prev);
    vectors++; if (ac - ac_prev !== -2) begin miscompares++; $display("FAIL w0_store_spacing: got %0d want 2", ac_prev - ac); end
    xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h0BADF00D || lt !== 1) begin miscompares++; $display("FAIL w0_load0: got %h lat=%0d want 0badf00d lat=1", rd, lt); end
    ac_prev = ac;
    xact(1'b0, 32'h46, 2'b01, 1'b1, 32'h0, 0, rd, er, lt, rl, st, ac);
    vectors++; if (rd !== 32'h00001357 || lt !== 1) begin miscompares++; $display("FAIL w0_load1: got %h lat=%0d want 00001357 lat=1", rd, lt); end
    vectors++; if (ac - ac_prev !== 2) begin miscompares++; $display("FAIL w0_load_spacing: got %0d want 2", ac - ac_prev); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half_backpressure;
    test_err;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's MEM stage: the target end of the load/store request interface the core initiates.
- Accepts one request at a time through a valid/ready handshake and inserts a configurable number of wait states.
- Commits stores with byte/half/word lane merging; returns loads sign- or zero-extended, with response backpressure.
- Sits beside the top level as the memory the core's load/store path reads and writes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array; power of two.
- WAIT_STATES, 2, cycles inserted between request accept and response; 0 allowed.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = invalid.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load result, extended; 0 for stores.
- resp_err  out  1  request was illegal (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=0 while rst=1 and 1 on the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/size/unsigned/wdata. Next state is WAIT with counter=WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
  - WAIT: req_ready=0; counter decrements each cycle. At counter==0, the next edge enters RESP.
  - RESP: resp_valid=1; outputs held stable until resp_ready=1. The accepting edge returns to IDLE.
- Latency: accept edge to resp_valid = WAIT_STATES+1 cycles.
- No new request is accepted in WAIT or RESP. The accept in IDLE and the resp_ready handshake in RESP never overlap, so throughput is one request per WAIT_STATES+2 cycles.
- Commit edge: the edge that enters RESP. On this edge a store writes its byte lanes and a load samples the array and latches resp_rdata.
- Word index = addr[2+log2(DEPTH_WORDS)-1:2]. Lanes are little-endian by addr[1:0].
- Store merge:
  - byte writes wdata[7:0] into lane addr[1:0];
  - half writes wdata[15:0] into lanes addr[1]*2..+1;
  - word writes all lanes.
  - Unselected lanes are unchanged.
- Load extract: selects the same lanes, shifts them to bit 0, then sign-extends from bit 7/15 or zero-extends per req_unsigned. A word load ignores req_unsigned.
- Store response: resp_rdata=0.
- Reset mid-operation:
  - in WAIT, the store is discarded and memory is unchanged;
  - in RESP, the store is already committed and the response is dropped.
- Inputs are ignored outside the IDLE handshake; changes to req_* during WAIT do not affect the latched request.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN.
- Defined: a request is illegal if any of the following holds:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size=11;
  - addr[ADDR_W-1:2] ≥ DEPTH_WORDS.
  - An illegal request has the same handshake and latency, no array write, resp_rdata=0 and resp_err=1.
- Not defined:
  - resp_err is tied to 0;
  - upper address bits are truncated, so the index wraps modulo DEPTH_WORDS;
  - a misaligned half uses lanes by addr[1]; a misaligned word ignores addr[1:0];
  - size=11 is treated as word.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10 -> resp_rdata=0xDEADBEEF; resp_valid exactly 3 cycles after accept (WAIT_STATES=2); req_ready=0 in between.
- After the word store, store byte 0x80 at 0x12, then load byte signed at 0x12 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word at 0x10 -> 0xDE80BEEF.
- Store half 0x1234 at 0x20; hold resp_ready=0 for 4 cycles -> resp_valid stays 1 and outputs stay stable; load half unsigned at 0x22 -> 0x00000000, at 0x20 -> 0x00001234.
- With DMEM_ERR_CHECK_EN, store word at 0x21 and load at address 4*DEPTH_WORDS -> both resp_err=1, rdata=0; word at 0x20 unchanged. Without the macro, the access at 4*DEPTH_WORDS aliases word 0.
- Assert rst during WAIT of a store of 0xCAFEF00D to 0x30 -> outputs return to reset values; a subsequent load from 0x30 returns the prior contents.
- WAIT_STATES=0 build: back-to-back load requests with resp_ready held 1 -> each response 1 cycle after accept; one request per 2 cycles.
